// File: rtl/serial_word_receiver_if.sv
// serial_word_receiver_if: serial bit stream in, parallel word handshake and status out
interface serial_word_receiver_if #(parameter int WIDTH = 8);
    logic             ser_in;
    logic             ser_valid;
    logic             ser_frame;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             dout_ready;
    logic             busy;
    logic             frame_err;
    logic             overrun;
    modport master (
        output ser_in, ser_valid, ser_frame, dout_ready,
        input  dout, dout_valid, busy, frame_err, overrun
    );
    modport slave (
        input  ser_in, ser_valid, ser_frame, dout_ready,
        output dout, dout_valid, busy, frame_err, overrun
    );
endinterface

// File: rtl/serial_word_receiver.sv
// serial_word_receiver: assembles WIDTH-bit words from a framed serial stream into a one-entry holding register
module serial_word_receiver #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1
) (
    input logic                   clock,
    input logic                   reset,
    serial_word_receiver_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
    typedef enum logic {IDLE, SHIFT} state_t;
    state_t           state, state_n;
    logic [CW-1:0]    count, count_inc, count_n;
    logic [WIDTH-1:0] sr, sr_n, dout, dout_n;
    logic             dout_valid, dout_valid_n, frame_err, frame_err_n, overrun, overrun_n;
    logic             accept, done, load;
    always_comb begin
        accept       = bus.ser_valid && (state == SHIFT || bus.ser_frame);
        sr_n         = !accept ? sr : MSB_FIRST ? {sr[WIDTH-2:0], bus.ser_in} : {bus.ser_in, sr[WIDTH-1:1]};
        // a frame marker always restarts the count; stale partial bits shift out before completion
        count_inc    = !accept ? count : bus.ser_frame ? CW'(1) : count + 1'b1;
        done         = accept && count_inc == CW'(WIDTH);
        count_n      = done ? '0 : count_inc;
        state_n      = done ? IDLE : accept ? SHIFT : state;
        load         = done && (!dout_valid || bus.dout_ready);
        dout_n       = load ? sr_n : dout;
        dout_valid_n = load || (dout_valid && !bus.dout_ready);
        frame_err_n  = bus.ser_valid && bus.ser_frame && state == SHIFT;
        overrun_n    = done && !load;
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            count      <= '0;
            sr         <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state      <= state_n;
            count      <= count_n;
            sr         <= sr_n;
            dout       <= dout_n;
            dout_valid <= dout_valid_n;
            frame_err  <= frame_err_n;
            overrun    <= overrun_n;
        end
    end
    assign bus.dout       = dout;
    assign bus.dout_valid = dout_valid;
    assign bus.busy       = state == SHIFT;
    assign bus.frame_err  = frame_err;
    assign bus.overrun    = overrun;
endmodule

// File: tb/tb_serial_word_receiver.sv
// tb_serial_word_receiver: drives one stream into MSB-first and LSB-first receivers, scoreboarding delivered words
module tb_serial_word_receiver;
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic ser_in = 1'b0, ser_valid = 1'b0, ser_frame = 1'b0, dout_ready = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic [7:0] q0[$];
    logic [7:0] q1[$];

    serial_word_receiver_if #(.WIDTH(8)) if0 ();
    serial_word_receiver_if #(.WIDTH(8)) if1 ();
    assign if0.ser_in = ser_in;
    assign if0.ser_valid = ser_valid;
    assign if0.ser_frame = ser_frame;
    assign if0.dout_ready = dout_ready;
    assign if1.ser_in = ser_in;
    assign if1.ser_valid = ser_valid;
    assign if1.ser_frame = ser_frame;
    assign if1.dout_ready = dout_ready;

    serial_word_receiver #(.WIDTH(8), .MSB_FIRST(1)) dut0 (.clock(clock), .reset(reset), .bus(if0));
    serial_word_receiver #(.WIDTH(8), .MSB_FIRST(0)) dut1 (.clock(clock), .reset(reset), .bus(if1));

    always #5 clock = ~clock;

    function automatic logic [7:0] rev8(input logic [7:0] w);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = w[7-i];
        return r;
    endfunction

    // one clock: scoreboard the handshake at the falling edge, then step past the rising edge
    task automatic tick();
        logic [7:0] e;
        @(negedge clock);
        if (!reset && if0.dout_valid && dout_ready) begin
            checks++;
            if (q0.size() == 0) begin
                errors++;
                $display("FAIL sb_msb unexpected word got %h want none", if0.dout);
            end else begin
                e = q0.pop_front();
                if (if0.dout !== e) begin
                    errors++;
                    $display("FAIL sb_msb got %h want %h", if0.dout, e);
                end
            end
        end
        if (!reset && if1.dout_valid && dout_ready) begin
            checks++;
            if (q1.size() == 0) begin
                errors++;
                $display("FAIL sb_lsb unexpected word got %h want none", if1.dout);
            end else begin
                e = q1.pop_front();
                if (if1.dout !== e) begin
                    errors++;
                    $display("FAIL sb_lsb got %h want %h", if1.dout, e);
                end
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic send_word(input logic [7:0] w, input int gap, input logic ovr, input logic ferr);
        if (!ovr) begin
            q0.push_back(w);
            q1.push_back(rev8(w));
        end
        for (int i = 0; i < 8; i++) begin
            ser_valid = 1'b1;
            ser_in    = w[7-i];
            ser_frame = (i == 0);
            tick();
            ser_valid = 1'b0;
            ser_frame = 1'b0;
            checks++;
            if ({if0.busy, if1.busy} !== {2{i < 7}}) begin
                errors++;
                $display("FAIL busy bit %0d got %b want %b", i, {if0.busy, if1.busy}, {2{i < 7}});
            end
            checks++;
            if ({if0.frame_err, if1.frame_err} !== {2{ferr && i == 0}}) begin
                errors++;
                $display("FAIL frame_err bit %0d got %b want %b", i, {if0.frame_err, if1.frame_err}, {2{ferr && i == 0}});
            end
            if (i == 7) begin
                checks++;
                if ({if0.dout_valid, if1.dout_valid, if0.overrun, if1.overrun} !== {2'b11, {2{ovr}}}) begin
                    errors++;
                    $display("FAIL word_done got %b want %b", {if0.dout_valid, if1.dout_valid, if0.overrun, if1.overrun}, {2'b11, {2{ovr}}});
                end
            end else begin
                repeat (gap) tick();
            end
        end
    endtask

    task automatic send_partial(input logic [7:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            ser_valid = 1'b1;
            ser_in    = w[7-i];
            ser_frame = (i == 0);
            tick();
        end
        ser_valid = 1'b0;
        ser_frame = 1'b0;
    endtask

    task automatic check_zero(input string name);
        checks++;
        if ({if0.dout, if1.dout, if0.dout_valid, if1.dout_valid, if0.busy, if1.busy,
             if0.frame_err, if1.frame_err, if0.overrun, if1.overrun} !== 26'd0) begin
            errors++;
            $display("FAIL %s got dout %h/%h v%b%b b%b%b fe%b%b ov%b%b want all 0", name, if0.dout, if1.dout,
                     if0.dout_valid, if1.dout_valid, if0.busy, if1.busy, if0.frame_err, if1.frame_err, if0.overrun, if1.overrun);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) tick();
        check_zero("reset");
        reset = 1'b0;
        tick();
        check_zero("idle_after_reset");
    endtask

    task automatic test_basic();
        send_word(8'hA5, 0, 1'b0, 1'b0);
        tick();
        send_word(8'hC0, 0, 1'b0, 1'b0);
        repeat (2) tick();
    endtask

    task automatic test_gaps();
        send_word(8'h3C, 3, 1'b0, 1'b0);
        repeat (2) tick();
    endtask

    task automatic test_idle_discard();
        ser_valid = 1'b1;
        ser_in    = 1'b1;
        repeat (3) tick();
        ser_valid = 1'b0;
        checks++;
        if ({if0.busy, if1.busy, if0.dout_valid, if1.dout_valid} !== 4'b0) begin
            errors++;
            $display("FAIL idle_discard got %b want 0000", {if0.busy, if1.busy, if0.dout_valid, if1.dout_valid});
        end
    endtask

    task automatic test_frame_err();
        send_partial(8'hFF, 4);
        send_word(8'hF0, 0, 1'b0, 1'b1);
        tick();
        checks++;
        if ({if0.frame_err, if1.frame_err, if0.dout_valid, if1.dout_valid} !== 4'b0) begin
            errors++;
            $display("FAIL frame_err_after got %b want 0000", {if0.frame_err, if1.frame_err, if0.dout_valid, if1.dout_valid});
        end
        tick();
    endtask

    task automatic test_back_to_back();
        send_word(8'h81, 0, 1'b0, 1'b0);
        send_word(8'h7E, 0, 1'b0, 1'b0);
        send_word(8'h96, 0, 1'b0, 1'b0);
        repeat (2) tick();
    endtask

    task automatic test_overrun();
        dout_ready = 1'b0;
        send_word(8'h11, 0, 1'b0, 1'b0);
        send_word(8'h22, 0, 1'b1, 1'b0);
        checks++;
        if ({if0.dout, if1.dout} !== {8'h11, 8'h88}) begin
            errors++;
            $display("FAIL overrun_hold got %h/%h want 11/88", if0.dout, if1.dout);
        end
        tick();
        checks++;
        if ({if0.overrun, if1.overrun, if0.dout_valid, if1.dout_valid} !== 4'b0011) begin
            errors++;
            $display("FAIL overrun_pulse got %b want 0011", {if0.overrun, if1.overrun, if0.dout_valid, if1.dout_valid});
        end
        q0.push_back(8'h33);
        q1.push_back(8'hCC);
        for (int i = 0; i < 8; i++) begin
            if (i == 7) dout_ready = 1'b1;
            ser_valid = 1'b1;
            ser_in    = 8'h33 >> (7 - i);
            ser_frame = (i == 0);
            tick();
        end
        ser_valid = 1'b0;
        ser_frame = 1'b0;
        checks++;
        if ({if0.dout, if1.dout, if0.dout_valid, if1.dout_valid, if0.overrun, if1.overrun} !== {8'h33, 8'hCC, 4'b1100}) begin
            errors++;
            $display("FAIL drain_fill got %h/%h v%b%b ov%b%b want 33/cc v11 ov00", if0.dout, if1.dout,
                     if0.dout_valid, if1.dout_valid, if0.overrun, if1.overrun);
        end
        repeat (2) tick();
    endtask

    task automatic test_reset_mid();
        send_partial(8'hFF, 4);
        reset = 1'b1;
        tick();
        check_zero("reset_mid");
        reset = 1'b0;
        send_word(8'h5A, 0, 1'b0, 1'b0);
        repeat (2) tick();
    endtask

    task automatic test_reset_held();
        dout_ready = 1'b0;
        send_word(8'h77, 0, 1'b0, 1'b0);
        void'(q0.pop_back());
        void'(q1.pop_back());
        reset = 1'b1;
        tick();
        check_zero("reset_held");
        reset = 1'b0;
        dout_ready = 1'b1;
        repeat (2) tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gaps();
        test_idle_discard();
        test_frame_err();
        test_back_to_back();
        test_overrun();
        test_reset_mid();
        test_reset_held();
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL sb_drain got %0d/%0d pending want 0/0", q0.size(), q1.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
